// File: rtl/riscv_imem_boot.sv
// Instruction memory for the single-cycle RISC-V core. A host streams a byte image into the
// memory while the core is held in reset, and the core is released to fetch once the load is complete.
module riscv_imem_boot #(
  parameter int unsigned           BW_D_IME  = 32,
  parameter int unsigned           BW_A_IME  = 16,
  parameter int unsigned           BW_A_MEM  = 10,
  parameter logic [BW_D_IME-1:0]   NOP_INSTR = 32'h00000013
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [BW_A_IME-1:0] i_imem_pc,
  output logic [BW_D_IME-1:0] o_imem_instr,
  output logic                o_cpu_rstn,
  input  logic                i_ld_valid,
  input  logic [7:0]          i_ld_data,
  output logic                o_ld_ready,
  input  logic                i_boot_req,
  output logic                o_boot_done,
  output logic                o_boot_err,
  output logic [15:0]         o_ld_wcnt
);

  localparam int unsigned DEPTH   = 1 << BW_A_MEM;
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  typedef enum logic [1:0] {HDR0, HDR1, DATA, RUN} state_t;

  state_t              state, state_nx;
  logic [15:0]         count;
  logic [1:0]          byte_idx;
  logic [23:0]         part;
  logic [BW_A_MEM-1:0] waddr;
  logic [15:0]         wcnt, wcnt_inc;
  logic                err, cpu_rstn, boot_done;
  logic                take, word_done, wr_en, restart;
  logic [BW_D_IME-1:0] word;
  logic                pc_unused;

  logic [BW_D_IME-1:0] mem [DEPTH];

  always_comb begin
    state_nx  = state;
    take      = i_ld_valid && (state != RUN);
    word_done = 1'b0;
    restart   = 1'b0;
    wcnt_inc  = wcnt + 16'd1;
    case (state)
      HDR0: if (take) state_nx = HDR1;
      HDR1: if (take) state_nx = ({i_ld_data, count[7:0]} == 16'd0) ? RUN : DATA;
      DATA: begin
        if (take && byte_idx == 2'd3) begin
          word_done = 1'b1;
          if (wcnt_inc == count) state_nx = RUN;
        end
      end
      RUN: begin
        if (i_boot_req) begin
          state_nx = HDR0;
          restart  = 1'b1;
        end
      end
      default: state_nx = HDR0;
    endcase
  end

  assign word  = {i_ld_data, part};
  // Words past the end of the array are still counted so the load runs to the header count.
  assign wr_en = word_done && ({1'b0, wcnt} < DEPTH_W);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= HDR0;
      count     <= '0;
      byte_idx  <= '0;
      part      <= '0;
      waddr     <= '0;
      wcnt      <= '0;
      err       <= 1'b0;
      cpu_rstn  <= 1'b0;
      boot_done <= 1'b0;
    end else begin
      state     <= state_nx;
      cpu_rstn  <= (state_nx == RUN);
      boot_done <= (state_nx == RUN);
      if (restart) begin
        err      <= 1'b0;
        byte_idx <= '0;
        waddr    <= '0;
        wcnt     <= '0;
      end
      if (take) begin
        case (state)
          HDR0: count[7:0] <= i_ld_data;
          HDR1: begin
            count[15:8] <= i_ld_data;
            if ({1'b0, i_ld_data, count[7:0]} > DEPTH_W) err <= 1'b1;
          end
          DATA: begin
            case (byte_idx)
              2'd0:    part[7:0]   <= i_ld_data;
              2'd1:    part[15:8]  <= i_ld_data;
              2'd2:    part[23:16] <= i_ld_data;
              default: ;
            endcase
            byte_idx <= byte_idx + 2'd1;
            if (word_done) begin
              waddr <= waddr + 1'b1;
              wcnt  <= wcnt_inc;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[waddr] <= word;
  end

  // Byte-offset bits and PC bits above the memory range do not take part in the fetch.
  assign pc_unused = ^{i_imem_pc[1:0], i_imem_pc[BW_A_IME-1:BW_A_MEM+2]};

  assign o_imem_instr = (state == RUN) ? mem[i_imem_pc[BW_A_MEM+1:2]] : NOP_INSTR;
  assign o_ld_ready   = (state != RUN);
  assign o_cpu_rstn   = cpu_rstn;
  assign o_boot_done  = boot_done;
  assign o_boot_err   = err;
  assign o_ld_wcnt    = wcnt;

endmodule

// File: tb/tb_riscv_imem_boot.sv
// Directed bench for riscv_imem_boot: a default-size instance plus a 4-word instance
// driven by the same byte stream, with hand-computed expectations.
module tb_riscv_imem_boot;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc = '0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = '0;
  logic        boot_req = 1'b0;

  logic [31:0] a_instr, b_instr;
  logic        a_rstn, b_rstn, a_ready, b_ready, a_done, b_done, a_err, b_err;
  logic [15:0] a_wcnt, b_wcnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  riscv_imem_boot dut_a (
    .i_clk(clk), .i_rst(rst), .i_imem_pc(pc), .o_imem_instr(a_instr), .o_cpu_rstn(a_rstn),
    .i_ld_valid(ld_valid), .i_ld_data(ld_data), .o_ld_ready(a_ready), .i_boot_req(boot_req),
    .o_boot_done(a_done), .o_boot_err(a_err), .o_ld_wcnt(a_wcnt)
  );

  riscv_imem_boot #(.BW_A_MEM(2)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_imem_pc(pc), .o_imem_instr(b_instr), .o_cpu_rstn(b_rstn),
    .i_ld_valid(ld_valid), .i_ld_data(ld_data), .o_ld_ready(b_ready), .i_boot_req(boot_req),
    .o_boot_done(b_done), .o_boot_err(b_err), .o_ld_wcnt(b_wcnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    ld_valid = 1'b1;
    ld_data  = b;
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  task automatic idle();
    @(negedge clk);
    ld_valid = 1'b0;
    ld_data  = 8'hFF;
    @(posedge clk);
    #1;
  endtask

  task automatic boot_pulse();
    @(negedge clk);
    boot_req = 1'b1;
    @(posedge clk);
    #1;
    boot_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic fetch_a(input string tag, input logic [15:0] addr, input logic [31:0] exp);
    pc = addr;
    #1;
    check(tag, a_instr, exp);
  endtask

  task automatic fetch_b(input string tag, input logic [15:0] addr, input logic [31:0] exp);
    pc = addr;
    #1;
    check(tag, b_instr, exp);
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_rstn",  a_rstn, 0);
    check("rst_done",  a_done, 0);
    check("rst_err",   a_err, 0);
    check("rst_wcnt",  a_wcnt, 0);
    check("rst_ready", a_ready, 1);
    fetch_a("rst_nop", 16'h0004, 32'h00000013);

    // Back-to-back load of two words
    send_byte(8'h02); send_byte(8'h00);
    send_word(32'h00100513);
    check("t1_wcnt1", a_wcnt, 1);
    send_byte(8'h93); send_byte(8'h05); send_byte(8'h20);
    check("t1_rstn_before", a_rstn, 0);
    send_byte(8'h00);
    check("t1_rstn",  a_rstn, 1);
    check("t1_done",  a_done, 1);
    check("t1_wcnt",  a_wcnt, 2);
    check("t1_ready", a_ready, 0);
    fetch_a("t1_pc4",    16'h0004, 32'h00200593);
    fetch_a("t1_pc0",    16'h0000, 32'h00100513);
    fetch_a("t1_pc7",    16'h0007, 32'h00200593);
    fetch_a("t1_alias",  16'h1004, 32'h00200593);

    // Reload request, then an overflowing load on the 4-word instance
    boot_pulse();
    check("t6a_rstn",  a_rstn, 0);
    check("t6a_ready", a_ready, 1);
    send_byte(8'h05); send_byte(8'h00);
    check("t4_b_err", b_err, 1);
    check("t4_a_err", a_err, 0);
    for (int k = 0; k < 5; k++) send_word(32'hC0DE0000 + k);
    check("t4_b_rstn", b_rstn, 1);
    check("t4_b_wcnt", b_wcnt, 5);
    check("t4_b_err2", b_err, 1);
    fetch_b("t4_b_pc0",  16'h0000, 32'hC0DE0000);
    fetch_b("t4_b_pc12", 16'h000C, 32'hC0DE0003);
    fetch_b("t4_b_pc16", 16'h0010, 32'hC0DE0000);
    fetch_a("t4_a_pc16", 16'h0010, 32'hC0DE0004);

    // Reload request clears the error and returns NOP
    boot_pulse();
    check("t6_rstn",  b_rstn, 0);
    check("t6_done",  b_done, 0);
    check("t6_err",   b_err, 0);
    check("t6_ready", b_ready, 1);
    fetch_b("t6_nop", 16'h0004, 32'h00000013);

    // Empty image
    send_byte(8'h00);
    check("t2_rstn_mid", a_rstn, 0);
    send_byte(8'h00);
    check("t2_rstn", a_rstn, 1);
    check("t2_done", a_done, 1);
    check("t2_wcnt", a_wcnt, 0);
    fetch_a("t2_pc0",   16'h0000, 32'hC0DE0000);
    fetch_a("t2_pc16",  16'h0010, 32'hC0DE0004);
    fetch_b("t2_b_pc8", 16'h0008, 32'hC0DE0002);

    // Gapped valid during header and data
    boot_pulse();
    send_byte(8'h02); idle(); send_byte(8'h00); idle();
    send_byte(8'h13); idle(); send_byte(8'h05); idle(); idle();
    check("t3_wcnt0", a_wcnt, 0);
    send_byte(8'h10); idle(); send_byte(8'h00);
    check("t3_wcnt1", a_wcnt, 1);
    idle();
    send_byte(8'h93); idle(); send_byte(8'h05); idle(); send_byte(8'h20); idle();
    check("t3_rstn_mid", a_rstn, 0);
    send_byte(8'h00);
    check("t3_rstn", a_rstn, 1);
    check("t3_wcnt", a_wcnt, 2);
    fetch_a("t3_pc0", 16'h0000, 32'h00100513);
    fetch_a("t3_pc4", 16'h0004, 32'h00200593);
    fetch_a("t3_pc8", 16'h0008, 32'hC0DE0002);

    // Reset in the middle of a load, then a clean reload
    boot_pulse();
    send_byte(8'h03); send_byte(8'h00);
    send_word(32'h44332211);
    send_byte(8'h55); send_byte(8'h66);
    check("t5_wcnt_pre", a_wcnt, 1);
    do_reset();
    check("t5_rstn",  a_rstn, 0);
    check("t5_done",  a_done, 0);
    check("t5_wcnt",  a_wcnt, 0);
    check("t5_ready", a_ready, 1);
    fetch_a("t5_nop", 16'h0000, 32'h00000013);
    send_byte(8'h01); send_byte(8'h00);
    send_word(32'hAABBCCDD);
    check("t5_rstn2", a_rstn, 1);
    check("t5_wcnt2", a_wcnt, 1);
    fetch_a("t5_pc0", 16'h0000, 32'hAABBCCDD);
    fetch_a("t5_pc4", 16'h0004, 32'h00200593);

    // Load bytes offered in RUN are refused
    send_byte(8'h77);
    check("run_wcnt", a_wcnt, 1);
    fetch_a("run_pc0", 16'h0000, 32'hAABBCCDD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
